// File: rtl/pwr_btn_press_gen.sv
// Virtual power-button press generator: times a BMC-requested press, then tracks the
// platform's power-state response and reports ok/timeout/abort/interlock.
module pwr_btn_press_gen #(
   parameter int unsigned SHORT_MS        = 200,
   parameter int unsigned LONG_MS         = 6000,
   parameter int unsigned RESP_TIMEOUT_MS = 10000,
   parameter int unsigned MIN_GAP_MS      = 1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        t1ms,
   input  logic        req,
   input  logic [1:0]  req_type,
   input  logic [15:0] req_len_ms,
   input  logic        abort,
   input  logic        st_steady_pwrok,
   input  logic        st_off_standby,
   input  logic        interlock_broken,
   output logic        vir_pwr_btn,
   output logic        busy,
   output logic        req_nak,
   output logic        done,
   output logic [1:0]  status
);

   localparam logic [15:0] SHORT_LEN   = 16'(SHORT_MS);
   localparam logic [15:0] LONG_LEN    = 16'(LONG_MS);
   localparam logic [15:0] TIMEOUT_LEN = 16'(RESP_TIMEOUT_MS);
   localparam logic [15:0] GAP_LEN     = 16'(MIN_GAP_MS);

   localparam logic [1:0] STAT_OK        = 2'b00;
   localparam logic [1:0] STAT_TIMEOUT   = 2'b01;
   localparam logic [1:0] STAT_ABORTED   = 2'b10;
   localparam logic [1:0] STAT_INTERLOCK = 2'b11;

   typedef enum logic [1:0] {StIdle, StPress, StWaitResp, StGap} state_e;

   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d, cnt_inc;
   logic [15:0] len_q, len_d;
   logic        was_on_q, was_on_d;
   logic        vir_q, busy_q;
   logic        nak_q, nak_d;
   logic        done_q, done_d;
   logic [1:0]  status_q, status_d;
   logic        success;

   // Thresholds compare against the post-tick value so the press ends on the tick
   // that brings the count to len, giving a (len-1, len] ms press.
   assign cnt_inc = (t1ms && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
   assign success = (was_on_q & st_off_standby) | (~was_on_q & st_steady_pwrok);

   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      was_on_d = was_on_q;
      nak_d    = 1'b0;
      done_d   = 1'b0;
      status_d = status_q;
      case (state_q)
         StIdle: begin
            if (req) begin
               if (req_type == 2'b11 || (req_type == 2'b10 && req_len_ms == 16'd0) ||
                   interlock_broken) begin
                  nak_d = 1'b1;
               end else begin
                  state_d  = StPress;
                  was_on_d = st_steady_pwrok;
                  case (req_type)
                     2'b00:   len_d = SHORT_LEN;
                     2'b01:   len_d = LONG_LEN;
                     default: len_d = req_len_ms;
                  endcase
               end
            end
         end
         StPress, StWaitResp: begin
            nak_d = req;
            if (interlock_broken) begin
               state_d  = StGap;
               done_d   = 1'b1;
               status_d = STAT_INTERLOCK;
            end else if (abort) begin
               state_d  = StGap;
               done_d   = 1'b1;
               status_d = STAT_ABORTED;
            end else if (state_q == StPress) begin
               if (cnt_inc == len_q) state_d = StWaitResp;
            end else if (success) begin
               state_d  = StGap;
               done_d   = 1'b1;
               status_d = STAT_OK;
            end else if (cnt_inc == TIMEOUT_LEN) begin
               state_d  = StGap;
               done_d   = 1'b1;
               status_d = STAT_TIMEOUT;
            end
         end
         StGap: begin
            nak_d = req;
            if (cnt_inc == GAP_LEN) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Counter restarts on every state entry and idles at zero.
   assign cnt_d = (state_d != state_q || state_q == StIdle) ? 16'd0 : cnt_inc;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         cnt_q    <= 16'd0;
         len_q    <= 16'd0;
         was_on_q <= 1'b0;
         vir_q    <= 1'b0;
         busy_q   <= 1'b0;
         nak_q    <= 1'b0;
         done_q   <= 1'b0;
         status_q <= STAT_OK;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         len_q    <= len_d;
         was_on_q <= was_on_d;
         vir_q    <= (state_d == StPress);
         busy_q   <= (state_d != StIdle);
         nak_q    <= nak_d;
         done_q   <= done_d;
         status_q <= status_d;
      end
   end

   assign vir_pwr_btn = vir_q;
   assign busy        = busy_q;
   assign req_nak     = nak_q;
   assign done        = done_q;
   assign status      = status_q;

endmodule
